// File: rtl/icache_controller.sv
// Instruction-fetch refill engine for the IF stage.
// On a flagged fetch miss it issues one line-sized AXI3 read burst, streams
// every returned beat to the cache array as a refill write, then pulses
// refill_complete. The most recently refilled line is kept in a one-line fill
// buffer that serves fetch hits combinationally.
//
// Ports:
//   clk, rst                - clock, synchronous active-low reset
//   addr, fetch_req         - CPU fetch byte address and request strobe
//   data_out, hit           - fill-buffer hit and word (combinational)
//   cache_miss_detected     - miss flag from the cache array for addr
//   refill_valid/_data      - one-cycle refill write strobe and word
//   refill_complete         - one-cycle strobe, line fill finished
//   ARADDR/ARVALID/ARREADY  - AXI read-address channel
//   RDATA/RVALID/RREADY     - AXI read-data channel
module icache_controller #(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned LINE_SIZE   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            addr,
    input  logic                   fetch_req,
    output logic [DATA_LENGTH-1:0] data_out,
    output logic                   hit,
    input  logic                   cache_miss_detected,
    output logic                   refill_valid,
    output logic [DATA_LENGTH-1:0] refill_data,
    output logic                   refill_complete,
    output logic [31:0]            ARADDR,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic [DATA_LENGTH-1:0] RDATA,
    input  logic                   RVALID,
    output logic                   RREADY
);

    localparam int unsigned WORDS = LINE_SIZE / (DATA_LENGTH / 8);
    localparam int unsigned OFF   = $clog2(LINE_SIZE);
    localparam int unsigned WIDX  = $clog2(WORDS);
    localparam int unsigned TAG_W = 32 - OFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_REFILL,
        S_DONE
    } state_t;

    state_t                 state;
    logic [WIDX-1:0]        beat;
    logic [TAG_W-1:0]       buf_tag;
    logic                   buf_valid;
    logic [DATA_LENGTH-1:0] line_buf [WORDS];
    logic [WIDX-1:0]        word_idx;

    // Byte-within-word bits do not select anything.
    logic                   unused_addr_lsb;
    assign unused_addr_lsb = ^addr[OFF-WIDX-1:0];

    assign word_idx = addr[OFF-1 -: WIDX];

    // Fill-buffer lookup; only answered while no refill is in flight.
    always_comb begin
        hit      = 1'b0;
        data_out = '0;
        if (fetch_req && (state == S_IDLE) && buf_valid && (addr[31:OFF] == buf_tag)) begin
            hit      = 1'b1;
            data_out = line_buf[word_idx];
        end
    end

    // Refill FSM with registered outputs; line_buf has no reset, buf_valid guards it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            ARVALID         <= 1'b0;
            ARADDR          <= '0;
            RREADY          <= 1'b0;
            refill_valid    <= 1'b0;
            refill_data     <= '0;
            refill_complete <= 1'b0;
            beat            <= '0;
            buf_tag         <= '0;
            buf_valid       <= 1'b0;
        end else begin
            refill_valid    <= 1'b0;
            refill_complete <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fetch_req && cache_miss_detected && !hit) begin
                        ARADDR  <= {addr[31:OFF], {OFF{1'b0}}};
                        ARVALID <= 1'b1;
                        beat    <= '0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (RVALID && RREADY) begin
                        refill_valid   <= 1'b1;
                        refill_data    <= RDATA;
                        line_buf[beat] <= RDATA;
                        beat           <= beat + WIDX'(1);
                        // No RLAST: the burst length is fixed, so count beats.
                        if (beat == WIDX'(WORDS - 1)) begin
                            RREADY <= 1'b0;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    refill_complete <= 1'b1;
                    buf_tag         <= ARADDR[31:OFF];
                    buf_valid       <= 1'b1;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// Directed testbench for icache_controller: reset, miss refill, fill-buffer
// hits, AR backpressure, R gaps, requests while busy, reset mid-burst.
module tb_icache_controller;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        fetch_req;
    logic [31:0] data_out;
    logic        hit;
    logic        cache_miss_detected;
    logic        refill_valid;
    logic [31:0] refill_data;
    logic        refill_complete;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        RREADY;

    int          checks;
    int          errors;
    logic [31:0] rv_q [$];
    int          cc;

    icache_controller dut (
        .clk                 (clk),
        .rst                 (rst),
        .addr                (addr),
        .fetch_req           (fetch_req),
        .data_out            (data_out),
        .hit                 (hit),
        .cache_miss_detected (cache_miss_detected),
        .refill_valid        (refill_valid),
        .refill_data         (refill_data),
        .refill_complete     (refill_complete),
        .ARADDR              (ARADDR),
        .ARVALID             (ARVALID),
        .ARREADY             (ARREADY),
        .RDATA               (RDATA),
        .RVALID              (RVALID),
        .RREADY              (RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every refill write and completion pulse.
    initial cc = 0;
    always @(negedge clk) begin
        if (refill_valid) rv_q.push_back(refill_data);
        if (refill_complete) cc = cc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_beats(input int n, input int gap, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            RVALID = 1'b1;
            RDATA  = base + 32'(i);
            @(negedge clk);
            if (gap > 0) begin
                RVALID = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        RVALID = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] a,
                          input logic exp_hit, input logic [31:0] exp_data);
        fetch_req = 1'b1;
        addr      = a;
        #1;
        check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        check({tag, "_data"}, data_out, exp_data);
        fetch_req = 1'b0;
    endtask

    int n0;
    int c0;

    initial begin
        checks              = 0;
        errors              = 0;
        rst                 = 1'b0;
        addr                = '0;
        fetch_req           = 1'b0;
        cache_miss_detected = 1'b0;
        ARREADY             = 1'b0;
        RDATA               = '0;
        RVALID              = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        check("rst_arvalid", 32'(ARVALID), 32'd0);
        check("rst_araddr", ARADDR, 32'd0);
        check("rst_rready", 32'(RREADY), 32'd0);
        check("rst_rvalid_out", 32'(refill_valid), 32'd0);
        check("rst_rdata_out", refill_data, 32'd0);
        check("rst_complete", 32'(refill_complete), 32'd0);
        lookup("rst_lookup", 32'h0000_1000, 1'b0, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Miss refill of line 0x1000
        addr = 32'h0000_1004; fetch_req = 1'b1; cache_miss_detected = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0; cache_miss_detected = 1'b0;
        check("miss_arvalid", 32'(ARVALID), 32'd1);
        check("miss_araddr", ARADDR, 32'h0000_1000);
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        check("miss_arvalid_drop", 32'(ARVALID), 32'd0);
        check("miss_rready", 32'(RREADY), 32'd1);
        n0 = rv_q.size();
        c0 = cc;
        drive_beats(16, 0, 32'd0);
        check("miss_rready_drop", 32'(RREADY), 32'd0);
        repeat (4) @(negedge clk);
        check("miss_beats", 32'(rv_q.size() - n0), 32'd16);
        for (int i = 0; i < 16 && (n0 + i) < rv_q.size(); i++)
            check($sformatf("miss_word%0d", i), rv_q[n0 + i], 32'(i));
        check("miss_complete", 32'(cc - c0), 32'd1);

        // Fill-buffer hits
        lookup("hit_1008", 32'h0000_1008, 1'b1, 32'd2);
        lookup("hit_103c", 32'h0000_103C, 1'b1, 32'd15);
        lookup("hit_100b", 32'h0000_100B, 1'b1, 32'd2);
        lookup("miss_2000", 32'h0000_2000, 1'b0, 32'd0);

        // AR backpressure, request during REQ ignored
        addr = 32'h0000_2044; fetch_req = 1'b1; cache_miss_detected = 1'b1;
        @(negedge clk);
        addr = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_arvalid%0d", i), 32'(ARVALID), 32'd1);
            check($sformatf("bp_araddr%0d", i), ARADDR, 32'h0000_2040);
            @(negedge clk);
        end
        fetch_req = 1'b0; cache_miss_detected = 1'b0;
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        check("bp_rready", 32'(RREADY), 32'd1);
        check("bp_arvalid_drop", 32'(ARVALID), 32'd0);

        // Fetch while busy: no hit, no new AR
        n0 = rv_q.size();
        c0 = cc;
        fetch_req = 1'b1; addr = 32'h0000_1008; cache_miss_detected = 1'b1;
        #1;
        check("busy_hit", 32'(hit), 32'd0);
        check("busy_data", data_out, 32'd0);
        drive_beats(1, 1, 32'h100);
        check("busy_arvalid", 32'(ARVALID), 32'd0);
        check("busy_araddr", ARADDR, 32'h0000_2040);
        fetch_req = 1'b0; cache_miss_detected = 1'b0;

        // Remaining beats with 1-cycle gaps
        drive_beats(15, 1, 32'h101);
        repeat (4) @(negedge clk);
        check("gap_beats", 32'(rv_q.size() - n0), 32'd16);
        if (rv_q.size() >= n0 + 16) begin
            check("gap_first", rv_q[n0], 32'h100);
            check("gap_last", rv_q[n0 + 15], 32'h10F);
        end
        check("gap_complete", 32'(cc - c0), 32'd1);
        lookup("gap_hit_2044", 32'h0000_2044, 1'b1, 32'h101);
        lookup("gap_hit_207c", 32'h0000_207C, 1'b1, 32'h10F);
        lookup("gap_old_line", 32'h0000_1008, 1'b0, 32'd0);

        // Reset mid-burst
        addr = 32'h0000_3010; fetch_req = 1'b1; cache_miss_detected = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0; cache_miss_detected = 1'b0;
        check("mid_araddr", ARADDR, 32'h0000_3000);
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        n0 = rv_q.size();
        c0 = cc;
        drive_beats(5, 0, 32'h200);
        rst = 1'b0;
        RVALID = 1'b1;
        RDATA  = 32'h205;
        @(negedge clk);
        check("mid_rready", 32'(RREADY), 32'd0);
        check("mid_arvalid", 32'(ARVALID), 32'd0);
        check("mid_refill_valid", 32'(refill_valid), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 11; i++) begin
            RDATA = 32'h206 + 32'(i);
            @(negedge clk);
        end
        RVALID = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rready_after", 32'(RREADY), 32'd0);
        check("mid_beats", 32'(rv_q.size() - n0), 32'd5);
        check("mid_complete", 32'(cc - c0), 32'd0);
        lookup("mid_buf_cleared", 32'h0000_2044, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
